// File: rtl/my_arb.sv
`default_nettype none
// ============================================================================
// Module   : my_arb
// Purpose  : Round-robin arbiter sharing one registered 8-bit data/valid bus
//            between N_REQ requesters. The owner keeps the bus for one packet
//            or at most MAX_BURST beats. Priority then rotates.
// Revision : 1.0 - initial release
// ============================================================================
module my_arb #(
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   gnt,
  output logic [7:0]         data,
  output logic               valid,
  output logic               busy,
  output logic [2:0]         owner
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_BUSY   = 1'b1;
  // Requester 0 wins first after reset, so the pointer starts on the last index.
  localparam logic [2:0] C_PTR_RST = 3'(N_REQ - 1);
  localparam logic [8:0] C_CNT_MAX = 9'(MAX_BURST - 1);
  localparam logic [3:0] C_NREQ    = 4'(N_REQ);

  logic [0:0] r_state;
  logic [2:0] r_owner;
  logic [2:0] r_last_win;
  logic [8:0] r_cnt;
  logic [7:0] r_data;
  logic       r_valid;

  logic [7:0]       w_req_pad;
  logic [7:0]       w_last_pad;
  logic [3:0]       w_idx;
  logic             w_found;
  logic [2:0]       w_winner;
  logic [N_REQ-1:0] w_gnt;
  logic [7:0]       w_own_data;
  logic             w_acc;
  logic             w_own_req;
  logic             w_own_last;
  logic             w_end_beat;

  // Pad the request vectors to 8 bits so a 3-bit index can address them.
  always_comb begin
    w_req_pad             = '0;
    w_last_pad            = '0;
    w_req_pad[N_REQ-1:0]  = req;
    w_last_pad[N_REQ-1:0] = req_last;
  end

  // Search from last_win+1 upward and wrap at N_REQ. The first requester found wins.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = {1'b0, r_last_win} + 4'(k);
      if (w_idx >= C_NREQ) begin
        w_idx = w_idx - C_NREQ;
      end
      if (!w_found && w_req_pad[w_idx[2:0]]) begin
        w_found  = 1'b1;
        w_winner = w_idx[2:0];
      end
    end
  end

  // The grant follows the owner's request while BUSY. Also select the owner's beat.
  always_comb begin
    w_gnt      = '0;
    w_own_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_owner == 3'(i)) begin
        w_gnt[i]   = (r_state == ST_BUSY) && req[i];
        w_own_data = req_data[8*i +: 8];
      end
    end
  end

  assign w_acc      = |w_gnt;
  assign w_own_req  = w_req_pad[r_owner];
  assign w_own_last = w_last_pad[r_owner];
  assign w_end_beat = w_acc && (w_own_last || (r_cnt == C_CNT_MAX));

  // Bus pipeline and arbitration state. Reset drops any partial packet at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_owner    <= '0;
      r_last_win <= C_PTR_RST;
      r_cnt      <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_valid <= w_acc;
      if (w_acc) begin
        r_data <= w_own_data;
      end
      if (r_state == ST_IDLE) begin
        if (w_found) begin
          r_owner <= w_winner;
          r_cnt   <= '0;
          r_state <= ST_BUSY;
        end
      end else begin
        // Release when the packet ends, when the burst cap is reached, or when the owner drops req.
        if (!w_own_req || w_end_beat) begin
          r_state    <= ST_IDLE;
          r_last_win <= r_owner;
          r_cnt      <= '0;
        end else if (w_acc) begin
          r_cnt <= r_cnt + 9'd1;
        end
      end
    end
  end

  assign gnt   = w_gnt;
  assign data  = r_data;
  assign valid = r_valid;
  assign busy  = (r_state == ST_BUSY);
  assign owner = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_my_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_my_arb
// Purpose  : Directed self-checking bench for my_arb. A scoreboard queue holds
//            the expected bus beats, and per-cycle checks cover grant timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_my_arb;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  gnt;
  logic [7:0]  data;
  logic        valid;
  logic        busy;
  logic [2:0]  owner;

  logic [2:0]  req3;
  logic [23:0] rdata3;
  logic [2:0]  last3;
  logic [2:0]  gnt3;
  logic [7:0]  data3;
  logic        valid3;
  logic        busy3;
  logic [2:0]  owner3;

  my_arb #(.N_REQ(4), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
    .gnt(gnt), .data(data), .valid(valid), .busy(busy), .owner(owner)
  );

  my_arb #(.N_REQ(3), .MAX_BURST(16)) dut3 (
    .clk(clk), .rst(rst), .req(req3), .req_data(rdata3), .req_last(last3),
    .gnt(gnt3), .data(data3), .valid(valid3), .busy(busy3), .owner(owner3)
  );

  // Per-requester beat sources: {last, data}
  logic [8:0] mem [4][64];
  int         rp [4];
  int         wp [4];
  logic [3:0] drop;
  logic [7:0] exp_q [$];
  int         checks;
  int         errors;
  logic [3:0] prev_gnt;
  int         run;
  int         run_max;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_src(input int i, input logic [7:0] d, input logic l);
    mem[i][wp[i]] = {l, d};
    wp[i]++;
  endtask

  task automatic clear_src();
    for (int i = 0; i < 4; i++) rp[i] = wp[i];
    drop = '0;
  endtask

  function automatic logic src_empty();
    logic e = 1'b1;
    for (int i = 0; i < 4; i++) if (rp[i] != wp[i]) e = 1'b0;
    return e;
  endfunction

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (rp[i] != wp[i] && !drop[i]) begin
        req[i]            = 1'b1;
        req_data[8*i +: 8] = mem[i][rp[i]][7:0];
        req_last[i]       = mem[i][rp[i]][8];
      end else begin
        req[i]            = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]       = 1'b0;
      end
    end
  endtask

  task automatic monitor();
    if (valid === 1'b1) begin
      chk("sb_beat_expected", {31'b0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) chk("sb_data", {24'b0, data}, {24'b0, exp_q.pop_front()});
    end
    if (rst) begin
      run     = 0;
      run_max = 0;
    end else if (gnt != 4'b0 && gnt == prev_gnt) begin
      run++;
    end else begin
      run = (gnt != 4'b0) ? 1 : 0;
    end
    prev_gnt = gnt;
    if (run > run_max) run_max = run;
    for (int i = 0; i < 4; i++) if (gnt[i] === 1'b1 && rp[i] != wp[i]) rp[i]++;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    monitor();
  endtask

  task automatic drain();
    int n = 0;
    while ((!src_empty() || busy !== 1'b0 || exp_q.size() != 0) && n < 200) begin
      cyc();
      n++;
    end
    chk("drain_timeout", {31'b0, n < 200}, 32'd1);
  endtask

  task automatic do_reset();
    #1 rst = 1'b1;
    clear_src();
    exp_q.delete();
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  function automatic logic [7:0] pat(input int i, input int k, input int b);
    return 8'((i << 4) | (k << 1) | b);
  endfunction

  initial begin
    rst = 1'b1; req = '0; req_data = '0; req_last = '0; drop = '0;
    req3 = '0; rdata3 = '0; last3 = '0;
    checks = 0; errors = 0; prev_gnt = '0; run = 0; run_max = 0;
    for (int i = 0; i < 4; i++) begin rp[i] = 0; wp[i] = 0; end

    // Reset values
    cyc(); cyc();
    chk("rst_data", {24'b0, data}, 32'h0);
    chk("rst_valid", {31'b0, valid}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_owner", {29'b0, owner}, 32'h0);
    chk("rst_gnt", {28'b0, gnt}, 32'h0);
    rst = 1'b0;
    cyc();
    chk("idle_gnt", {28'b0, gnt}, 32'h0);

    // Single requester 2: 11, 22, 33(last)
    push_src(2, 8'h11, 1'b0); push_src(2, 8'h22, 1'b0); push_src(2, 8'h33, 1'b1);
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    cyc(); chk("s1_T_busy", {31'b0, busy}, 32'h0);
    cyc(); chk("s1_busy", {31'b0, busy}, 32'h1);
    chk("s1_owner", {29'b0, owner}, 32'd2);
    chk("s1_gnt", {28'b0, gnt}, 32'h4);
    chk("s1_nobeat", {31'b0, valid}, 32'h0);
    cyc(); chk("s1_v0", {31'b0, valid}, 32'h1); chk("s1_d0", {24'b0, data}, 32'h11);
    chk("s1_gnt1", {28'b0, gnt}, 32'h4);
    cyc(); chk("s1_d1", {24'b0, data}, 32'h22); chk("s1_gnt2", {28'b0, gnt}, 32'h4);
    cyc(); chk("s1_d2", {24'b0, data}, 32'h33); chk("s1_end_busy", {31'b0, busy}, 32'h0);
    chk("s1_end_gnt", {28'b0, gnt}, 32'h0);
    drain();

    // Round robin: all four hold req, two 2-beat packets each
    do_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++) begin
        push_src(i, pat(i, k, 0), 1'b0);
        push_src(i, pat(i, k, 1), 1'b1);
        exp_q.push_back(pat(i, k, 0));
        exp_q.push_back(pat(i, k, 1));
      end
    cyc();
    for (int p = 0; p < 8; p++) begin
      cyc();
      chk("rr_owner", {29'b0, owner}, 32'(p % 4));
      chk("rr_gnt", {28'b0, gnt}, 32'(1 << (p % 4)));
      chk("rr_bubble", {31'b0, valid}, 32'h0);
      cyc();
      cyc();
      chk("rr_idle", {31'b0, busy}, 32'h0);
      chk("rr_valid", {31'b0, valid}, 32'h1);
    end
    drain();

    // Burst cap (MAX_BURST=4): requester 1 sends 10 beats while requester 3 sends 4
    do_reset();
    for (int n = 0; n < 10; n++) push_src(1, 8'(8'hA0 + n), n == 9);
    for (int n = 0; n < 4; n++) push_src(3, 8'(8'hC0 + n), n == 3);
    for (int n = 0; n < 4; n++) exp_q.push_back(8'(8'hA0 + n));
    for (int n = 0; n < 4; n++) exp_q.push_back(8'(8'hC0 + n));
    for (int n = 4; n < 10; n++) exp_q.push_back(8'(8'hA0 + n));
    drain();
    chk("burst_run_max", 32'(run_max), 32'd4);

    // Owner drop: requester 0 releases req after 2 of 5 beats
    do_reset();
    for (int n = 0; n < 5; n++) push_src(0, 8'(8'hD0 + n), n == 4);
    push_src(1, 8'hE0, 1'b0); push_src(1, 8'hE1, 1'b1);
    exp_q.push_back(8'hD0); exp_q.push_back(8'hD1);
    exp_q.push_back(8'hE0); exp_q.push_back(8'hE1);
    cyc();
    cyc(); chk("drop_owner0", {29'b0, owner}, 32'd0); chk("drop_busy", {31'b0, busy}, 32'h1);
    cyc(); drop[0] = 1'b1;
    cyc(); chk("drop_gnt", {28'b0, gnt}, 32'h0); chk("drop_lastbeat", {31'b0, valid}, 32'h1);
    cyc(); chk("drop_valid", {31'b0, valid}, 32'h0); chk("drop_idle", {31'b0, busy}, 32'h0);
    rp[0] = wp[0]; drop = '0;
    cyc(); chk("drop_next_owner", {29'b0, owner}, 32'd1); chk("drop_next_busy", {31'b0, busy}, 32'h1);
    drain();

    // Asynchronous reset during beat 3 of a packet
    for (int n = 0; n < 6; n++) push_src(0, 8'(8'hF0 + n), n == 5);
    exp_q.push_back(8'hF0); exp_q.push_back(8'hF1);
    cyc();
    cyc(); chk("ar_owner_pre", {29'b0, owner}, 32'd0); chk("ar_busy_pre", {31'b0, busy}, 32'h1);
    cyc();
    cyc();
    #1 rst = 1'b1;
    #1;
    chk("ar_valid", {31'b0, valid}, 32'h0);
    chk("ar_busy", {31'b0, busy}, 32'h0);
    chk("ar_data", {24'b0, data}, 32'h0);
    chk("ar_owner", {29'b0, owner}, 32'h0);
    clear_src();
    for (int i = 0; i < 4; i++) begin
      push_src(i, 8'(8'h30 + i), 1'b1);
      exp_q.push_back(8'(8'h30 + i));
    end
    cyc();
    rst = 1'b0;
    cyc(); chk("ar_first_owner", {29'b0, owner}, 32'd0); chk("ar_first_gnt", {28'b0, gnt}, 32'h1);
    drain();

    // Pointer wrap with N_REQ=3
    req3 = 3'b011; rdata3 = {8'h77, 8'h66, 8'h55}; last3 = 3'b011;
    cyc(); chk("w3_owner", {29'b0, owner3}, 32'd0); chk("w3_gnt", {29'b0, gnt3}, 32'h1);
    cyc(); chk("w3_idle", {31'b0, busy3}, 32'h0); chk("w3_data", {24'b0, data3}, 32'h55);
    chk("w3_valid", {31'b0, valid3}, 32'h1);
    req3 = 3'b001;
    cyc(); chk("w3_owner2", {29'b0, owner3}, 32'd0); chk("w3_busy2", {31'b0, busy3}, 32'h1);
    chk("w3_gnt2", {29'b0, gnt3}, 32'h1);
    req3 = 3'b000;
    cyc(); chk("w3_drop_valid", {31'b0, valid3}, 32'h0); chk("w3_drop_busy", {31'b0, busy3}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
